// File: rtl/te_ingress_buffer.sv
// rtl/te_ingress_buffer.sv - compacting circular ingress buffer between trace connector and encoder
//
// Purpose:
//   Accepts up to N_IN trace blocks per cycle (no backpressure), compacts the
//   valid slots into a DEPTH-entry ring and presents up to N_OUT of the oldest
//   entries per cycle to the encoder. A cycle group that does not fit in the
//   free space at cycle start is dropped whole; the loss is recorded in a
//   sticky overflow flag and a saturating lost-block counter.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   valid_i [N_IN]                   per-slot valid, any pattern
//   iretire_i/ilastsize_i/itype_i/
//   iaddr_i [N_IN x w]               per-slot block fields (slot-major, flat)
//   cause_i/tval_i/priv_i            fields shared by the cycle's group
//   ready_i                          encoder takes every presented lane
//   valid_o [N_OUT]                  thermometer lane valid, lane 0 oldest
//   *_o [N_OUT x w]                  per-lane entry fields, zero on idle lanes
//   count_o                          occupied entries
//   overflow_o                       sticky drop flag
//   lost_cnt_o                       saturating dropped-block count

package connector_pkg;
   localparam int XLEN        = 64;
   localparam int IRETIRE_LEN = 32;
   localparam int ITYPE_LEN   = 3;
   localparam int CAUSE_LEN   = 5;
   localparam int PRIV_LEN    = 2;
endpackage

module te_ingress_buffer
   import connector_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int N_OUT  = 2,
   parameter int DEPTH  = 8,
   parameter int LOST_W = 16,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [N_IN-1:0]              valid_i,
   input  logic [N_IN*IRETIRE_LEN-1:0]  iretire_i,
   input  logic [N_IN-1:0]              ilastsize_i,
   input  logic [N_IN*ITYPE_LEN-1:0]    itype_i,
   input  logic [N_IN*XLEN-1:0]         iaddr_i,
   input  logic [CAUSE_LEN-1:0]         cause_i,
   input  logic [XLEN-1:0]              tval_i,
   input  logic [PRIV_LEN-1:0]          priv_i,
   input  logic                         ready_i,
   output logic [N_OUT-1:0]             valid_o,
   output logic [N_OUT*IRETIRE_LEN-1:0] iretire_o,
   output logic [N_OUT-1:0]             ilastsize_o,
   output logic [N_OUT*ITYPE_LEN-1:0]   itype_o,
   output logic [N_OUT*XLEN-1:0]        iaddr_o,
   output logic [N_OUT*CAUSE_LEN-1:0]   cause_o,
   output logic [N_OUT*XLEN-1:0]        tval_o,
   output logic [N_OUT*PRIV_LEN-1:0]    priv_o,
   output logic [CW-1:0]                count_o,
   output logic                         overflow_o,
   output logic [LOST_W-1:0]            lost_cnt_o
);

   // Entry storage; contents are deliberately not reset.
   logic [IRETIRE_LEN-1:0] mem_iretire   [DEPTH];
   logic                   mem_ilastsize [DEPTH];
   logic [ITYPE_LEN-1:0]   mem_itype     [DEPTH];
   logic [XLEN-1:0]        mem_iaddr     [DEPTH];
   logic [CAUSE_LEN-1:0]   mem_cause     [DEPTH];
   logic [XLEN-1:0]        mem_tval      [DEPTH];
   logic [PRIV_LEN-1:0]    mem_priv      [DEPTH];

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic              overflow_q;
   logic [LOST_W-1:0] lost_q;

   logic [CW-1:0]     k;
   logic [PW-1:0]     widx [N_IN];
   logic [CW-1:0]     free;
   logic              accept;
   logic              drop;
   logic [CW-1:0]     m;
   logic              pop;
   logic [CW-1:0]     count_next;
   logic [LOST_W:0]   lost_sum;
   logic [PW-1:0]     ridx;

   // Compaction: each valid slot lands at wr_ptr plus the number of valid
   // slots below it, so k doubles as a running prefix count.
   always_comb begin
      k = '0;
      for (int i = 0; i < N_IN; i++) begin
         widx[i] = wr_ptr + k[PW-1:0];
         k       = k + CW'(valid_i[i]);
      end
   end

   // Free space is judged on the cycle-start count only; a pop in the same
   // cycle does not make room for this cycle's group.
   always_comb begin
      free       = CW'(DEPTH) - count_q;
      accept     = (k != '0) && (k <= free);
      drop       = (k > free);
      m          = (count_q < CW'(N_OUT)) ? count_q : CW'(N_OUT);
      pop        = ready_i && (m != '0);
      count_next = count_q + (accept ? k : '0) - (pop ? m : '0);
      lost_sum   = {1'b0, lost_q} + (LOST_W+1)'(k);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         lost_q     <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + k[PW-1:0];
         end
         if (pop) begin
            rd_ptr <= rd_ptr + m[PW-1:0];
         end
         count_q <= count_next;
         if (drop) begin
            overflow_q <= 1'b1;
            lost_q     <= lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N_IN; i++) begin
         if (!rst_i && accept && valid_i[i]) begin
            mem_iretire[widx[i]]   <= iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
            mem_ilastsize[widx[i]] <= ilastsize_i[i];
            mem_itype[widx[i]]     <= itype_i[i*ITYPE_LEN +: ITYPE_LEN];
            mem_iaddr[widx[i]]     <= iaddr_i[i*XLEN +: XLEN];
            mem_cause[widx[i]]     <= cause_i;
            mem_tval[widx[i]]      <= tval_i;
            mem_priv[widx[i]]      <= priv_i;
         end
      end
   end

   // Lanes are a pure function of registered state: nothing pushed this
   // cycle can appear until after the edge.
   always_comb begin
      valid_o     = '0;
      iretire_o   = '0;
      ilastsize_o = '0;
      itype_o     = '0;
      iaddr_o     = '0;
      cause_o     = '0;
      tval_o      = '0;
      priv_o      = '0;
      ridx        = '0;
      for (int j = 0; j < N_OUT; j++) begin
         ridx = rd_ptr + PW'(j);
         if (count_q > CW'(j)) begin
            valid_o[j]                              = 1'b1;
            iretire_o[j*IRETIRE_LEN +: IRETIRE_LEN] = mem_iretire[ridx];
            ilastsize_o[j]                          = mem_ilastsize[ridx];
            itype_o[j*ITYPE_LEN +: ITYPE_LEN]       = mem_itype[ridx];
            iaddr_o[j*XLEN +: XLEN]                 = mem_iaddr[ridx];
            cause_o[j*CAUSE_LEN +: CAUSE_LEN]       = mem_cause[ridx];
            tval_o[j*XLEN +: XLEN]                  = mem_tval[ridx];
            priv_o[j*PRIV_LEN +: PRIV_LEN]          = mem_priv[ridx];
         end
      end
   end

   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign lost_cnt_o = lost_q;

endmodule

// File: tb/tb_te_ingress_buffer.sv
// tb/tb_te_ingress_buffer.sv - self-checking bench for te_ingress_buffer
module tb_te_ingress_buffer;
   import connector_pkg::*;

   localparam int N_IN   = 2;
   localparam int N_OUT  = 2;
   localparam int DEPTH  = 8;
   localparam int LOST_W = 16;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int LOST_MAX = (1 << LOST_W) - 1;

   logic                         clk;
   logic                         rst;
   logic [N_IN-1:0]              valid;
   logic [N_IN*IRETIRE_LEN-1:0]  iretire;
   logic [N_IN-1:0]              ilastsize;
   logic [N_IN*ITYPE_LEN-1:0]    itype;
   logic [N_IN*XLEN-1:0]         iaddr;
   logic [CAUSE_LEN-1:0]         cause;
   logic [XLEN-1:0]              tval;
   logic [PRIV_LEN-1:0]          priv;
   logic                         ready;
   logic [N_OUT-1:0]             valid_o;
   logic [N_OUT*IRETIRE_LEN-1:0] iretire_o;
   logic [N_OUT-1:0]             ilastsize_o;
   logic [N_OUT*ITYPE_LEN-1:0]   itype_o;
   logic [N_OUT*XLEN-1:0]        iaddr_o;
   logic [N_OUT*CAUSE_LEN-1:0]   cause_o;
   logic [N_OUT*XLEN-1:0]        tval_o;
   logic [N_OUT*PRIV_LEN-1:0]    priv_o;
   logic [CW-1:0]                count_o;
   logic                         overflow_o;
   logic [LOST_W-1:0]            lost_cnt_o;

   te_ingress_buffer #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .LOST_W(LOST_W)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .iretire_i(iretire),
      .ilastsize_i(ilastsize), .itype_i(itype), .iaddr_i(iaddr), .cause_i(cause),
      .tval_i(tval), .priv_i(priv), .ready_i(ready), .valid_o(valid_o),
      .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
      .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
      .count_o(count_o), .overflow_o(overflow_o), .lost_cnt_o(lost_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IRETIRE_LEN-1:0] iretire;
      logic                   ilastsize;
      logic [ITYPE_LEN-1:0]   itype;
      logic [XLEN-1:0]        iaddr;
      logic [CAUSE_LEN-1:0]   cause;
      logic [XLEN-1:0]        tval;
      logic [PRIV_LEN-1:0]    priv;
   } ent_t;

   ent_t q[$];
   bit   m_ovf;
   int   m_lost;
   int   tests;
   int   fails;
   bit   chk_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of entries updated once per rising edge.
   always @(posedge clk) begin
      int   kk;
      int   fr;
      int   mm;
      ent_t e;
      if (rst) begin
         q.delete();
         m_ovf  = 1'b0;
         m_lost = 0;
      end else begin
         kk = $countones(valid);
         fr = DEPTH - q.size();
         mm = (q.size() < N_OUT) ? q.size() : N_OUT;
         if (ready) begin
            for (int i = 0; i < mm; i++) void'(q.pop_front());
         end
         if (kk > 0 && kk <= fr) begin
            for (int i = 0; i < N_IN; i++) begin
               if (valid[i]) begin
                  e.iretire   = iretire[i*IRETIRE_LEN +: IRETIRE_LEN];
                  e.ilastsize = ilastsize[i];
                  e.itype     = itype[i*ITYPE_LEN +: ITYPE_LEN];
                  e.iaddr     = iaddr[i*XLEN +: XLEN];
                  e.cause     = cause;
                  e.tval      = tval;
                  e.priv      = priv;
                  q.push_back(e);
               end
            end
         end else if (kk > fr) begin
            m_ovf  = 1'b1;
            m_lost = (m_lost + kk > LOST_MAX) ? LOST_MAX : m_lost + kk;
         end
      end
   end

   // Compare process: outputs depend only on state, so check mid-cycle.
   always @(negedge clk) begin
      int          em;
      logic [63:0] ev;
      logic [63:0] ea;
      logic [63:0] et;
      logic [63:0] emisc;
      if (chk_en) begin
         em = (q.size() < N_OUT) ? q.size() : N_OUT;
         ev = (64'd1 << em) - 64'd1;
         check("valid_o", 64'(valid_o), ev);
         check("count_o", 64'(count_o), 64'(q.size()));
         check("overflow_o", 64'(overflow_o), 64'(m_ovf));
         check("lost_cnt_o", 64'(lost_cnt_o), 64'(m_lost));
         for (int j = 0; j < N_OUT; j++) begin
            if (j < em) begin
               ea    = q[j].iaddr;
               et    = q[j].tval;
               emisc = 64'({q[j].iretire, q[j].ilastsize, q[j].itype, q[j].cause, q[j].priv});
            end else begin
               ea = '0; et = '0; emisc = '0;
            end
            check($sformatf("lane%0d_iaddr", j), iaddr_o[j*XLEN +: XLEN], ea);
            check($sformatf("lane%0d_tval", j), tval_o[j*XLEN +: XLEN], et);
            check($sformatf("lane%0d_misc", j),
                  64'({iretire_o[j*IRETIRE_LEN +: IRETIRE_LEN], ilastsize_o[j],
                       itype_o[j*ITYPE_LEN +: ITYPE_LEN], cause_o[j*CAUSE_LEN +: CAUSE_LEN],
                       priv_o[j*PRIV_LEN +: PRIV_LEN]}), emisc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      for (int i = 0; i < N_IN; i++) begin
         iretire[i*IRETIRE_LEN +: IRETIRE_LEN] = $urandom;
         itype[i*ITYPE_LEN +: ITYPE_LEN]       = ITYPE_LEN'($urandom);
         iaddr[i*XLEN +: XLEN]                 = {$urandom, $urandom};
      end
      ilastsize = N_IN'($urandom);
      cause     = CAUSE_LEN'($urandom);
      tval      = {$urandom, $urandom};
      priv      = PRIV_LEN'($urandom);
   endtask

   task automatic push2(input logic [1:0] v, input logic [63:0] base);
      rand_fields();
      valid           = v;
      iaddr[63:0]     = base;
      iaddr[127:64]   = base + 64'd4;
      tick();
   endtask

   initial begin
      chk_en = 1'b0;
      rst    = 1'b1;
      ready  = 1'b0;
      valid  = 2'b11;
      rand_fields();
      tick();
      tick();
      check("rst_valid_o", 64'(valid_o), 64'd0);
      check("rst_count_o", 64'(count_o), 64'd0);
      check("rst_overflow_o", 64'(overflow_o), 64'd0);
      check("rst_lost_cnt_o", 64'(lost_cnt_o), 64'd0);
      rst    = 1'b0;
      valid  = '0;
      chk_en = 1'b1;

      // Compaction of a lone upper slot into lane 0
      rand_fields();
      valid           = 2'b10;
      iaddr[127:64]   = 64'h8000_0010;
      itype[5:3]      = 3'd1;
      priv            = 2'd3;
      tick();
      valid = '0;
      check("cmp_valid_o", 64'(valid_o), 64'h1);
      check("cmp_iaddr0", iaddr_o[63:0], 64'h8000_0010);
      check("cmp_itype0", 64'(itype_o[2:0]), 64'd1);
      check("cmp_priv0", 64'(priv_o[1:0]), 64'd3);
      check("cmp_count_o", 64'(count_o), 64'd1);
      check("cmp_lane1_iaddr", iaddr_o[127:64], 64'd0);
      check("cmp_lane1_itype", 64'(itype_o[5:3]), 64'd0);
      ready = 1'b1;
      tick();
      ready = 1'b0;

      // Streaming with pointer wrap
      ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         push2(2'b11, 64'h1000 + 64'(8 * c));
         check("ord_lane0", iaddr_o[63:0], 64'h1000 + 64'(8 * c));
         check("ord_lane1", iaddr_o[127:64], 64'h1004 + 64'(8 * c));
         check("ord_count", 64'(count_o), 64'd2);
      end
      valid = '0;
      tick();
      ready = 1'b0;

      // Overflow while stalled, then ordered drain
      for (int c = 0; c < 4; c++) push2(2'b11, 64'h2000 + 64'(8 * c));
      check("ovf_full_count", 64'(count_o), 64'd8);
      push2(2'b11, 64'h3000);
      check("ovf_count", 64'(count_o), 64'd8);
      check("ovf_flag", 64'(overflow_o), 64'd1);
      check("ovf_lost2", 64'(lost_cnt_o), 64'd2);
      push2(2'b01, 64'h3100);
      check("ovf_lost3", 64'(lost_cnt_o), 64'd3);
      valid = '0;
      ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check("drain_lane0", iaddr_o[63:0], 64'h2000 + 64'(8 * c));
         check("drain_lane1", iaddr_o[127:64], 64'h2004 + 64'(8 * c));
         tick();
      end
      check("drain_count", 64'(count_o), 64'd0);
      ready = 1'b0;

      // Pop does not make room for a same-cycle push when full
      for (int c = 0; c < 4; c++) push2(2'b11, 64'h4000 + 64'(8 * c));
      ready = 1'b1;
      push2(2'b11, 64'h5000);
      check("full_pp_count", 64'(count_o), 64'd6);
      check("full_pp_lost", 64'(lost_cnt_o), 64'd5);
      check("full_pp_lane0", iaddr_o[63:0], 64'h4008);
      valid = '0;
      tick();
      ready = 1'b0;
      push2(2'b01, 64'h6000);
      valid = '0;
      check("mid_count5", 64'(count_o), 64'd5);

      // Reset wins over simultaneous push and pop
      rst   = 1'b1;
      ready = 1'b1;
      valid = 2'b11;
      tick();
      rst   = 1'b0;
      ready = 1'b0;
      valid = '0;
      check("mid_rst_count", 64'(count_o), 64'd0);
      check("mid_rst_ovf", 64'(overflow_o), 64'd0);
      check("mid_rst_lost", 64'(lost_cnt_o), 64'd0);
      check("mid_rst_valid", 64'(valid_o), 64'd0);

      // Randomized traffic with shifting ready pressure
      for (int c = 0; c < 3000; c++) begin
         int bias;
         bias  = (c / 250) % 4;
         rst   = ($urandom_range(0, 399) == 0);
         valid = N_IN'($urandom);
         ready = ($urandom_range(0, 3) < bias);
         rand_fields();
         tick();
      end
      rst   = 1'b0;
      valid = '0;
      ready = 1'b0;
      tick();
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
